seq_serializer: RTL

//   Upstream stimulus stage for the bit-serial sequence detector. Captures a
//   W-bit pattern word (e.g. from board switches) on a load request and

---
 rtl/seq_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - loads a W-bit pattern and shifts it out MSB-first, one bit per DIV clocks.
// Optional build macro SEQSER_LOOP_EN adds a loop input that repeats the held word back-to-back.
module seq_serializer #(
  parameter int W   = 4,
  parameter int DIV = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   abort,
`ifdef SEQSER_LOOP_EN
  input  logic                   loop,
`endif
  input  logic [W-1:0]           din,
  output logic                   x,
  output logic                   x_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(W+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            x_q, x_d;
  logic            xv_q, xv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
  logic            finish;
`ifdef SEQSER_LOOP_EN
  logic [W-1:0]    held_q, held_d;
`endif

  assign tick = (presc_q == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQSER_LOOP_EN
      held_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQSER_LOOP_EN
      held_q  <= held_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    xv_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    finish  = 1'b0;
`ifdef SEQSER_LOOP_EN
    held_d  = held_q;
`endif
    case (state_q)
      ST_IDLE: begin
        x_d = 1'b0;
        // abort has priority: a simultaneous load is dropped
        if (!abort && load) begin
          sr_d    = din;
          presc_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef SEQSER_LOOP_EN
          held_d  = din;
`endif
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          x_d     = 1'b0;
          sr_d    = '0;
          presc_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (cnt_q != CW'(W)) begin
              x_d   = sr_q[W-1];
              sr_d  = sr_q << 1;
              cnt_d = cnt_q + 1'b1;
              xv_d  = 1'b1;
            end else begin
              // bit_cnt==W on a tick marks the end of the last bit period
              finish = 1'b1;
`ifdef SEQSER_LOOP_EN
              if (loop) begin
                x_d    = held_q[W-1];
                sr_d   = held_q << 1;
                cnt_d  = CW'(1);
                xv_d   = 1'b1;
                done_d = 1'b1;
                finish = 1'b0;
              end
`endif
              if (finish) begin
                x_d     = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        x_d     = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        x_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule
